// File: rtl/kulisch_dot_seq.sv
// Sequencer and accumulator controller for the Kulisch product shifter.
// Registers decoded products toward the shifter and folds each shifted term into a wide accumulator.
module kulisch_dot_seq #(
  parameter int unsigned MAN_W       = 6,
  parameter int unsigned EXP_W       = 4,
  parameter int unsigned ACC_DESIRED = 32,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [MAN_W-1:0]       in_man,
  input  logic [EXP_W-1:0]       in_exp,
  input  logic                   in_sign,
  input  logic                   in_last,
  output logic [MAN_W-1:0]       sh_man,
  output logic [EXP_W-1:0]       sh_exp,
  output logic                   sh_sign,
  input  logic [ACC_DESIRED-1:0] sh_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_DESIRED-1:0] out_acc,
  output logic                   out_ovf,
  output logic [CNT_W-1:0]       out_count
);

  localparam int unsigned ACC_W = ACC_DESIRED;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_OUT
  } state_t;

  state_t             state_q;
  logic [MAN_W-1:0]   sh_man_q;
  logic [EXP_W-1:0]   sh_exp_q;
  logic               sh_sign_q;
  logic               s1_valid_q;
  logic               s1_last_q;
  logic               s1_first_q;
  logic               out_valid_q;
  logic [ACC_W-1:0]   acc_q;
  logic               ovf_q;
  logic [CNT_W-1:0]   count_q;

  logic               accept;
  logic [ACC_W-1:0]   sum;
  logic               ovf_step;
  logic [ACC_W-1:0]   acc_d;
  logic               ovf_d;
  logic [CNT_W-1:0]   count_d;

  // in_ready follows reset directly so it reads 0 while reset is held and 1 as soon as it drops.
  assign in_ready = !reset && ((state_q == S_IDLE) || (state_q == S_RUN));
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    sum      = acc_q + sh_result;
    ovf_step = (acc_q[ACC_W-1] == sh_result[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
    acc_d    = sum;
    ovf_d    = ovf_q | ovf_step;
    count_d  = (&count_q) ? count_q : count_q + CNT_W'(1);
    if (s1_first_q) begin
      acc_d   = sh_result;
      ovf_d   = 1'b0;
      count_d = CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sh_man_q    <= '0;
      sh_exp_q    <= '0;
      sh_sign_q   <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_first_q  <= 1'b0;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      count_q     <= '0;
    end else if (flush) begin
      state_q     <= S_IDLE;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_first_q  <= 1'b0;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      count_q     <= '0;
    end else begin
      s1_valid_q <= accept;
      s1_last_q  <= accept && in_last;
      s1_first_q <= accept && (state_q == S_IDLE);
      if (accept) begin
        sh_man_q  <= in_man;
        sh_exp_q  <= in_exp;
        sh_sign_q <= in_sign;
      end

      if (s1_valid_q) begin
        acc_q   <= acc_d;
        ovf_q   <= ovf_d;
        count_q <= count_d;
      end

      unique case (state_q)
        S_IDLE: begin
          if (accept) state_q <= in_last ? S_DRAIN : S_RUN;
        end
        S_RUN: begin
          if (accept && in_last) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (s1_valid_q && s1_last_q) begin
            state_q     <= S_OUT;
            out_valid_q <= 1'b1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sh_man    = sh_man_q;
  assign sh_exp    = sh_exp_q;
  assign sh_sign   = sh_sign_q;
  assign out_valid = out_valid_q;
  assign out_acc   = acc_q;
  assign out_ovf   = ovf_q;
  assign out_count = count_q;

endmodule
